// File: rtl/adc_sample_avg.sv
// adc_sample_avg: block averager for signed ADC samples.
// Each hab_i pulse adds data_i[DW-1:0] to a wide signed accumulator. Every
// 2^LOG2N samples the block mean is placed in a one-entry valid/ready output
// stage. A result that arrives while the stage is still held is dropped and
// the sticky ovr_o flag is set.
// Optional build macro ADC_AVG_ROUND_EN: round half up instead of floor.
module adc_sample_avg #(
    parameter int DW    = 24,
    parameter int LOG2N = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hab_i,
    input  logic [31:0]   data_i,
    input  logic          clr_i,
    input  logic          ready_i,
    output logic [DW-1:0] avg_o,
    output logic          valid_o,
    output logic          ovr_o,
    output logic [6:0]    fill_o
);
    // The extra LOG2N bits hold the sum of 2^LOG2N samples without overflow.
    localparam int         AW   = DW + LOG2N;
    localparam logic [6:0] LAST = 7'((1 << LOG2N) - 1);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t           state;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] sample;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] sum_biased;
    logic signed [AW-1:0] sum_shifted;
    logic        [DW-1:0] result;
    logic                 last;
    logic                 done;

    assign sample = signed'(data_i[DW-1:0]);
    assign sum    = acc + AW'(sample);

`ifdef ADC_AVG_ROUND_EN
    // Half an LSB of the result; zero when LOG2N is 0.
    localparam logic signed [AW-1:0] BIAS = AW'((1 << LOG2N) >> 1);
    assign sum_biased = sum + BIAS;
`else
    assign sum_biased = sum;
`endif

    assign sum_shifted = sum_biased >>> LOG2N;
    assign result      = sum_shifted[DW-1:0];
    assign last        = (fill_o == LAST);
    assign done        = hab_i && last;

    // Accumulate samples and restart from zero once a block completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc    <= '0;
            fill_o <= '0;
        end else if (clr_i) begin
            acc    <= '0;
            fill_o <= '0;
        end else if (hab_i) begin
            if (last) begin
                acc    <= '0;
                fill_o <= '0;
            end else begin
                acc    <= sum;
                fill_o <= fill_o + 7'd1;
            end
        end
    end

    // Output stage: holds one result until it is accepted, flags drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= OUT_EMPTY;
            avg_o   <= '0;
            valid_o <= 1'b0;
            ovr_o   <= 1'b0;
        end else if (clr_i) begin
            state   <= OUT_EMPTY;
            valid_o <= 1'b0;
            ovr_o   <= 1'b0;
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (done) begin
                        avg_o   <= result;
                        valid_o <= 1'b1;
                        state   <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (ready_i) begin
                        if (done) begin
                            avg_o <= result;
                        end else begin
                            valid_o <= 1'b0;
                            state   <= OUT_EMPTY;
                        end
                    end else if (done) begin
                        ovr_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= OUT_EMPTY;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_avg.sv
// Bench for adc_sample_avg: one instance with LOG2N=2 and one with LOG2N=0,
// both sharing the same stimulus, checked against a block-mean model.
`timescale 1ns/1ps
module tb_adc_sample_avg;
    localparam int DW = 24;
`ifdef ADC_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          hab   = 1'b0;
    logic          clr   = 1'b0;
    logic          ready = 1'b0;
    logic [31:0]   data  = '0;
    logic [DW-1:0] avg_a   [2];
    logic          valid_a [2];
    logic          ovr_a   [2];
    logic [6:0]    fill_a  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adc_sample_avg #(.DW(DW), .LOG2N(2)) dut0 (
        .clk_i(clk), .rst_i(rst), .hab_i(hab), .data_i(data), .clr_i(clr),
        .ready_i(ready), .avg_o(avg_a[0]), .valid_o(valid_a[0]),
        .ovr_o(ovr_a[0]), .fill_o(fill_a[0])
    );

    adc_sample_avg #(.DW(DW), .LOG2N(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .hab_i(hab), .data_i(data), .clr_i(clr),
        .ready_i(ready), .avg_o(avg_a[1]), .valid_o(valid_a[1]),
        .ovr_o(ovr_a[1]), .fill_o(fill_a[1])
    );

    // Reference model: running block sum/count and a one-slot output holder.
    longint m_sum   [2];
    int     m_cnt   [2];
    bit     m_valid [2];
    bit     m_ovr   [2];
    longint m_avg   [2];

    function automatic longint sext(input logic [31:0] d);
        logic signed [DW-1:0] s;
        s = signed'(d[DW-1:0]);
        return longint'(s);
    endfunction

    function automatic longint block_mean(input longint total, input int n);
        longint t;
        longint q;
        t = total + (ROUND ? longint'(n / 2) : 64'sd0);
        q = t / n;
        if ((t % n) != 0 && t < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_ovr[k] = 0; m_avg[k] = 0;
        end
    endfunction

    function automatic void model_step(input bit h, input logic [31:0] d,
                                       input bit r, input bit c);
        int     n;
        longint res;
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 4 : 1;
            if (c) begin
                m_sum[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
            end else begin
                if (m_valid[k] && r) m_valid[k] = 0;
                if (h) begin
                    m_sum[k] = m_sum[k] + sext(d);
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == n) begin
                        res = block_mean(m_sum[k], n);
                        m_sum[k] = 0;
                        m_cnt[k] = 0;
                        if (m_valid[k]) m_ovr[k] = 1;
                        else begin
                            m_valid[k] = 1;
                            m_avg[k]   = res;
                        end
                    end
                end
            end
        end
    endfunction

    // Apply one cycle of inputs just after an edge; return just after the next.
    task automatic step(input bit h, input logic [31:0] d, input bit r, input bit c);
        hab = h; data = d; ready = r; clr = c;
        model_step(h, d, r, c);
        @(posedge clk);
        #1;
        hab = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (avg_a[k] !== '0 || valid_a[k] !== 1'b0 || ovr_a[k] !== 1'b0 || fill_a[k] !== 7'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got avg=%0d valid=%b ovr=%b fill=%0d, want all 0",
                         k, avg_a[k], valid_a[k], ovr_a[k], fill_a[k]);
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int s [4] = '{10, 20, 30, 40};
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, s[i], 1, 0);
        checks++;
        if (valid_a[0] !== 1'b0 || fill_a[0] !== 7'd3) begin
            errors++;
            $display("FAIL basic_partial: got valid=%b fill=%0d, want valid=0 fill=3", valid_a[0], fill_a[0]);
        end
        step(1, s[3], 1, 0);
        checks++;
        if (valid_a[0] !== 1'b1 || $signed(avg_a[0]) !== 24'sd25 || fill_a[0] !== 7'd0) begin
            errors++;
            $display("FAIL basic_result: got valid=%b avg=%0d fill=%0d, want 1 25 0",
                     valid_a[0], $signed(avg_a[0]), fill_a[0]);
        end
        step(0, 0, 1, 0);
        checks++;
        if (valid_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_transfer: got valid=%b, want 0", valid_a[0]);
        end
    endtask

    task automatic test_rounding();
        int neg [4] = '{-1, -2, -3, -4};
        int mix [4] = '{1, 2, 2, 1};
        step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, neg[i], 1, 0);
        checks++;
        if ($signed(avg_a[0]) !== (ROUND ? -24'sd2 : -24'sd3) || valid_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL negative_avg: got avg=%0d valid=%b, want %0d 1",
                     $signed(avg_a[0]), valid_a[0], ROUND ? -2 : -3);
        end
        for (int i = 0; i < 4; i++) step(1, mix[i], 1, 0);
        checks++;
        if ($signed(avg_a[0]) !== (ROUND ? 24'sd2 : 24'sd1) || valid_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL half_avg: got avg=%0d valid=%b, want %0d 1",
                     $signed(avg_a[0]), valid_a[0], ROUND ? 2 : 1);
        end
    endtask

    task automatic test_overrun();
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 100, 0, 0);
        checks++;
        if (valid_a[0] !== 1'b1 || $signed(avg_a[0]) !== 24'sd100 || ovr_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got valid=%b avg=%0d ovr=%b, want 1 100 0",
                     valid_a[0], $signed(avg_a[0]), ovr_a[0]);
        end
        for (int i = 0; i < 4; i++) step(1, 100, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 200, 0, 0);
        checks++;
        if (valid_a[0] !== 1'b1 || $signed(avg_a[0]) !== 24'sd100 || ovr_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_held: got valid=%b avg=%0d ovr=%b, want 1 100 1",
                     valid_a[0], $signed(avg_a[0]), ovr_a[0]);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        checks++;
        if (valid_a[0] !== 1'b0 || ovr_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got valid=%b ovr=%b, want 0 1", valid_a[0], ovr_a[0]);
        end
        step(0, 0, 0, 1);
        checks++;
        if (ovr_a[0] !== 1'b0 || $signed(avg_a[0]) !== 24'sd100) begin
            errors++;
            $display("FAIL ovr_clear: got ovr=%b avg=%0d, want 0 100", ovr_a[0], $signed(avg_a[0]));
        end
    endtask

    task automatic test_reset_and_clear();
        step(0, 0, 1, 1);
        step(1, 99, 1, 0);
        step(1, 99, 1, 0);
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (fill_a[0] !== 7'd0 || avg_a[0] !== '0) begin
            errors++;
            $display("FAIL async_reset: got fill=%0d avg=%0d, want 0 0", fill_a[0], avg_a[0]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 8, 1, 0);
        checks++;
        if (valid_a[0] !== 1'b1 || $signed(avg_a[0]) !== 24'sd8) begin
            errors++;
            $display("FAIL reset_discard: got valid=%b avg=%0d, want 1 8", valid_a[0], $signed(avg_a[0]));
        end
        step(1, 7, 1, 0);
        step(1, 50, 1, 1);
        checks++;
        if (fill_a[0] !== 7'd0 || valid_a[0] !== 1'b0 || $signed(avg_a[0]) !== 24'sd8) begin
            errors++;
            $display("FAIL clr_with_hab: got fill=%0d valid=%b avg=%0d, want 0 0 8",
                     fill_a[0], valid_a[0], $signed(avg_a[0]));
        end
        for (int i = 0; i < 4; i++) step(1, 5, 1, 0);
        checks++;
        if ($signed(avg_a[0]) !== 24'sd5 || valid_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_clr: got avg=%0d valid=%b, want 5 1", $signed(avg_a[0]), valid_a[0]);
        end
    endtask

    task automatic test_log2n0();
        int s [3] = '{-7, 123, 8388607};
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, s[i], 1, 0);
            checks++;
            if (valid_a[1] !== 1'b1 || $signed(avg_a[1]) !== 24'(s[i]) || fill_a[1] !== 7'd0) begin
                errors++;
                $display("FAIL log2n0_pass[%0d]: got valid=%b avg=%0d fill=%0d, want 1 %0d 0",
                         i, valid_a[1], $signed(avg_a[1]), fill_a[1], s[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e_avg;
        bit            h, r, c;
        step(0, 0, 1, 1);
        for (int i = 0; i < 800; i++) begin
            h = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 99) == 0);
            step(h, $urandom, r, c);
            for (int k = 0; k < 2; k++) begin
                e_avg = DW'(m_avg[k]);
                checks++;
                if (avg_a[k] !== e_avg || valid_a[k] !== m_valid[k] ||
                    ovr_a[k] !== m_ovr[k] || fill_a[k] !== 7'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d: got avg=%0d valid=%b ovr=%b fill=%0d, want avg=%0d valid=%b ovr=%b fill=%0d",
                             i, k, $signed(avg_a[k]), valid_a[k], ovr_a[k], fill_a[k],
                             $signed(e_avg), m_valid[k], m_ovr[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_rounding();
        test_overrun();
        test_reset_and_clear();
        test_log2n0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
